// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC launch-pattern sequencer.
package tdc_pkg;

  typedef enum logic [1:0] {
    PG_IDLE  = 2'd0,
    PG_LEVEL = 2'd1,
    PG_TOG   = 2'd2,
    PG_BURST = 2'd3
  } pg_mode_t;

  // Output path select: REG drives pg_q, BYPASS drives the D-input pg_next.
  localparam logic PG_REG    = 1'b0;
  localparam logic PG_BYPASS = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEVEL = 3'd1,
    S_TOG   = 3'd2,
    S_EDGE  = 3'd3,
    S_GAP   = 3'd4
  } launch_state_t;

  localparam int BURST_W_DEF = 8;
  localparam int GAP_W_DEF   = 4;

endpackage

// File: rtl/tdc_gap_cnt.sv
// Loadable down-counter timing the idle cycles between burst edges.
// expire flags the last gap cycle so the sequencer can return to S_EDGE.
module tdc_gap_cnt
  import tdc_pkg::*;
#(
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             launch_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             dec,
  input  logic [GAP_W-1:0] load_val,
  output logic             expire
);

  logic [GAP_W-1:0] cnt_reg;

  always_ff @(posedge launch_clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (en) begin
      if (load) begin
        cnt_reg <= load_val;
      end else if (dec && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  assign expire = (cnt_reg == GAP_W'(1));

endmodule

// File: rtl/tdc_launch_seq.sv
// Launch-pattern sequencer feeding the delay-line TDC: idle, level, free toggle and counted bursts.
// Define TDC_LAUNCH_RTZ_EN for return-to-zero bursts (rising launches only, each followed by a forced return).
module tdc_launch_seq
  import tdc_pkg::*;
#(
  parameter int BURST_W = BURST_W_DEF,
  parameter int GAP_W   = GAP_W_DEF
) (
  input  logic               launch_clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [1:0]         mode,
  input  logic               level_in,
  input  logic               bypass,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [GAP_W-1:0]   gap,
  output logic               pg_out,
  output logic               edge_strobe,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] edge_cnt
);

  launch_state_t      state_reg, state_next;
  logic               pg_q, pg_next;
  logic [BURST_W-1:0] edge_cnt_reg, edge_cnt_next, cnt_inc;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               edge_strobe_reg;
  logic               gap_load, gap_dec, gap_expire;

  assign cnt_inc = edge_cnt_reg + 1'b1;

  // With ena low every default holds, so pg_next == pg_q and the bypass path freezes too.
  always_comb begin
    state_next    = state_reg;
    pg_next       = pg_q;
    edge_cnt_next = edge_cnt_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    gap_load      = 1'b0;
    gap_dec       = 1'b0;
    if (ena) begin
      case (state_reg)
        S_IDLE: begin
          case (mode)
            PG_LEVEL: state_next = S_LEVEL;
            PG_TOG: begin
              state_next    = S_TOG;
              edge_cnt_next = '0;
            end
            PG_BURST: begin
              if (start) begin
                if (burst_len != '0) begin
                  state_next    = S_EDGE;
                  edge_cnt_next = '0;
                  busy_next     = 1'b1;
                end else begin
                  done_next = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
        S_LEVEL: begin
          pg_next = level_in;
          if (mode != PG_LEVEL) state_next = S_IDLE;
        end
        S_TOG: begin
          if (mode != PG_TOG) begin
            state_next = S_IDLE;
          end else begin
            pg_next       = ~pg_q;
            edge_cnt_next = cnt_inc;
          end
        end
        S_EDGE: begin
          if (mode != PG_BURST) begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
          end else begin
`ifdef TDC_LAUNCH_RTZ_EN
            // pg_q high means this cycle is a return (or the uncounted pre-burst fall).
            if (!pg_q) begin
              pg_next       = 1'b1;
              edge_cnt_next = cnt_inc;
            end else begin
              pg_next = 1'b0;
              if (edge_cnt_reg == burst_len) begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
              end else if (gap != '0 && edge_cnt_reg != '0) begin
                gap_load   = 1'b1;
                state_next = S_GAP;
              end
            end
`else
            pg_next       = ~pg_q;
            edge_cnt_next = cnt_inc;
            if (cnt_inc == burst_len) begin
              state_next = S_IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end else if (gap != '0) begin
              gap_load   = 1'b1;
              state_next = S_GAP;
            end
`endif
          end
        end
        S_GAP: begin
          if (mode != PG_BURST) begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
          end else begin
            gap_dec = 1'b1;
            if (gap_expire) state_next = S_EDGE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge launch_clk) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      pg_q            <= 1'b0;
      edge_cnt_reg    <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      edge_strobe_reg <= 1'b0;
    end else if (ena) begin
      state_reg       <= state_next;
      pg_q            <= pg_next;
      edge_cnt_reg    <= edge_cnt_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      edge_strobe_reg <= (pg_next != pg_q);
    end
  end

  tdc_gap_cnt #(
    .GAP_W (GAP_W)
  ) u_gap_cnt (
    .launch_clk (launch_clk),
    .rst_n      (rst_n),
    .en         (ena),
    .load       (gap_load),
    .dec        (gap_dec),
    .load_val   (gap),
    .expire     (gap_expire)
  );

  assign pg_out      = (bypass == PG_BYPASS) ? pg_next : pg_q;
  assign edge_strobe = edge_strobe_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign edge_cnt    = edge_cnt_reg;

endmodule
